// File: rtl/dmem_arbiter_pkg.sv
// rtl/dmem_arbiter_pkg.sv - shared constants, state enum and helpers for the data-memory arbiter
package dmem_arbiter_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    // Access size in bytes; 0 marks an encoding with no defined size
    function automatic logic [2:0] f3_size(input logic [2:0] f3);
        case (f3)
            F3_B, F3_BU: f3_size = 3'd1;
            F3_H, F3_HU: f3_size = 3'd2;
            F3_W:        f3_size = 3'd4;
            default:     f3_size = 3'd0;
        endcase
    endfunction

    function automatic logic f3_legal(input logic [2:0] f3);
        f3_legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                   (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

endpackage

// File: rtl/dmem_rr_pick.sv
// rtl/dmem_rr_pick.sv - two-way round-robin winner selection
module dmem_rr_pick (
    input  logic [1:0] req,
    input  logic       last_winner,
    output logic       valid,
    output logic       winner
);

    // On a tie the requester that did not win last time takes the port
    always_comb begin
        valid  = |req;
        winner = (req == 2'b11) ? ~last_winner : req[1];
    end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port round-robin arbiter and single-strobe access sequencer
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MEM_BYTES = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              r0_req,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    input  logic [2:0]        r0_funct3,
    output logic              r0_gnt,
    output logic              r0_rvalid,
    output logic [DATA_W-1:0] r0_rdata,
    output logic              r0_err,
    input  logic              r1_req,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    input  logic [2:0]        r1_funct3,
    output logic              r1_gnt,
    output logic              r1_rvalid,
    output logic [DATA_W-1:0] r1_rdata,
    output logic              r1_err,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [2:0]        mem_funct3,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_t              state;
    logic                last_winner;
    logic                lat_we;
    logic                lat_id;
    logic                lat_err;
    logic                read_q;
    logic                write_q;
    logic [DATA_W-1:0]   result;

    logic                pick_valid;
    logic                pick_id;
    logic                sel_we;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic [2:0]          sel_funct3;
    logic [2:0]          sel_size;
    logic [ADDR_W:0]     sel_end;
    logic                sel_err;

    dmem_rr_pick u_pick (
        .req         ({r1_req, r0_req}),
        .last_winner (last_winner),
        .valid       (pick_valid),
        .winner      (pick_id)
    );

    // Steer the winner's fields and classify the access before it is latched
    always_comb begin
        sel_we     = pick_id ? r1_we     : r0_we;
        sel_addr   = pick_id ? r1_addr   : r0_addr;
        sel_wdata  = pick_id ? r1_wdata  : r0_wdata;
        sel_funct3 = pick_id ? r1_funct3 : r0_funct3;
        sel_size   = f3_size(sel_funct3);
        // One extra bit keeps the end-address sum from wrapping near the top of the address space
        sel_end    = {1'b0, sel_addr} + (ADDR_W+1)'(sel_size);
        sel_err    = !f3_legal(sel_funct3)
                  || (sel_we && sel_funct3[2])
                  || ((sel_size == 3'd2) && sel_addr[0])
                  || ((sel_size == 3'd4) && (sel_addr[1:0] != 2'b00))
                  || (sel_end > (ADDR_W+1)'(MEM_BYTES));
    end

    // Sequencer: arbitrate in IDLE/RESP, one strobe cycle in ACCESS, completion in RESP
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            last_winner <= 1'b1;
            lat_we      <= 1'b0;
            lat_id      <= 1'b0;
            lat_err     <= 1'b0;
            read_q      <= 1'b0;
            write_q     <= 1'b0;
            result      <= '0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_funct3  <= '0;
            r0_gnt      <= 1'b0;
            r1_gnt      <= 1'b0;
            r0_rvalid   <= 1'b0;
            r1_rvalid   <= 1'b0;
            r0_err      <= 1'b0;
            r1_err      <= 1'b0;
        end else begin
            r0_gnt    <= 1'b0;
            r1_gnt    <= 1'b0;
            r0_rvalid <= 1'b0;
            r1_rvalid <= 1'b0;
            r0_err    <= 1'b0;
            r1_err    <= 1'b0;
            read_q    <= 1'b0;
            write_q   <= 1'b0;
            case (state)
                ST_IDLE, ST_RESP: begin
                    if (pick_valid) begin
                        state       <= ST_ACCESS;
                        last_winner <= pick_id;
                        lat_id      <= pick_id;
                        lat_we      <= sel_we;
                        lat_err     <= sel_err;
                        mem_addr    <= sel_addr;
                        mem_wdata   <= sel_wdata;
                        mem_funct3  <= sel_funct3;
                        read_q      <= !sel_err && !sel_we;
                        write_q     <= !sel_err && sel_we;
                        r0_gnt      <= !pick_id;
                        r1_gnt      <= pick_id;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    state     <= ST_RESP;
                    result    <= (lat_err || lat_we) ? '0 : mem_rdata;
                    r0_rvalid <= !lat_id;
                    r1_rvalid <= lat_id;
                    r0_err    <= !lat_id && lat_err;
                    r1_err    <= lat_id && lat_err;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Reset in the middle of ACCESS must not let the store commit
    assign mem_read  = read_q  && !rst;
    assign mem_write = write_q && !rst;
    assign r0_rdata  = result;
    assign r1_rdata  = result;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req;
    logic [1:0]  we;
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic [2:0]  f3    [2];
    logic [1:0]  gnt;
    logic [1:0]  rvalid;
    logic [1:0]  err;
    logic [31:0] rdata [2];
    logic        mem_read, mem_write;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [2:0]  mem_funct3;

    int vectors    = 0;
    int miscompares = 0;

    logic [7:0]  mem [0:4095];
    logic [7:0]  b0, b1, b2, b3;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_BYTES(4096)) dut (
        .clk(clk), .rst(rst),
        .r0_req(req[0]), .r0_we(we[0]), .r0_addr(addr[0]), .r0_wdata(wdata[0]), .r0_funct3(f3[0]),
        .r0_gnt(gnt[0]), .r0_rvalid(rvalid[0]), .r0_rdata(rdata[0]), .r0_err(err[0]),
        .r1_req(req[1]), .r1_we(we[1]), .r1_addr(addr[1]), .r1_wdata(wdata[1]), .r1_funct3(f3[1]),
        .r1_gnt(gnt[1]), .r1_rvalid(rvalid[1]), .r1_rdata(rdata[1]), .r1_err(err[1]),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_funct3(mem_funct3), .mem_rdata(mem_rdata)
    );

    // Byte memory model: combinational read formatted by access type
    always_comb begin
        b0 = mem[mem_addr[11:0]];
        b1 = mem[mem_addr[11:0] + 12'd1];
        b2 = mem[mem_addr[11:0] + 12'd2];
        b3 = mem[mem_addr[11:0] + 12'd3];
        case (mem_funct3)
            3'b000:  mem_rdata = {{24{b0[7]}}, b0};
            3'b001:  mem_rdata = {{16{b1[7]}}, b1, b0};
            3'b010:  mem_rdata = {b3, b2, b1, b0};
            3'b100:  mem_rdata = {24'h0, b0};
            3'b101:  mem_rdata = {16'h0, b1, b0};
            default: mem_rdata = 32'h0;
        endcase
    end

    always @(posedge clk) begin
        if (mem_write) begin
            mem[mem_addr[11:0]] <= mem_wdata[7:0];
            if (mem_funct3 != 3'b000) mem[mem_addr[11:0] + 12'd1] <= mem_wdata[15:8];
            if (mem_funct3 == 3'b010) begin
                mem[mem_addr[11:0] + 12'd2] <= mem_wdata[23:16];
                mem[mem_addr[11:0] + 12'd3] <= mem_wdata[31:24];
            end
        end
    end

    function automatic logic [31:0] mem_word(input int a);
        return {mem[a+3], mem[a+2], mem[a+1], mem[a]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Present one request now; checks the ACCESS cycle, then the RESP cycle
    task automatic do_access(input int id, input logic w, input logic [31:0] a, input logic [31:0] d,
                             input logic [2:0] f, input logic [31:0] exp_rd, input logic exp_err);
        req[id] = 1'b1; we[id] = w; addr[id] = a; wdata[id] = d; f3[id] = f;
        tick();
        chk("gnt", {30'h0, gnt}, (id == 0) ? 32'd1 : 32'd2);
        chk("mem_read", {31'h0, mem_read}, {31'h0, !exp_err && !w});
        chk("mem_write", {31'h0, mem_write}, {31'h0, !exp_err && w});
        chk("mem_addr", mem_addr, a);
        req[id] = 1'b0; addr[id] = 32'hFFFF_FFFF; wdata[id] = 32'h0BAD_0BAD; f3[id] = 3'b111;
        tick();
        chk("rvalid", {30'h0, rvalid}, (id == 0) ? 32'd1 : 32'd2);
        chk("err", {31'h0, err[id]}, {31'h0, exp_err});
        chk("rdata", rdata[id], exp_rd);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        {mem[16'h103], mem[16'h102], mem[16'h101], mem[16'h100]} = 32'hA0A0_0100;
        {mem[16'h203], mem[16'h202], mem[16'h201], mem[16'h200]} = 32'hB1B1_0200;
        {mem[16'h043], mem[16'h042], mem[16'h041], mem[16'h040]} = 32'hA5A5_A5A5;
        {mem[16'hFFF], mem[16'hFFE], mem[16'hFFD], mem[16'hFFC]} = 32'h1122_3344;
        rst = 1'b1; req = 2'b00; we = 2'b00;
        for (int i = 0; i < 2; i++) begin
            addr[i] = 32'h0; wdata[i] = 32'h0; f3[i] = 3'b010;
        end
        tick();
        tick();
        chk("rst_gnt", {30'h0, gnt}, 32'h0);
        chk("rst_rvalid", {30'h0, rvalid}, 32'h0);
        chk("rst_strobes", {30'h0, mem_read, mem_write}, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_rdata", rdata[0], 32'h0);

        // Continuous contention from reset: r0 first, then strict alternation
        rst = 1'b0;
        req = 2'b11; we = 2'b00;
        addr[0] = 32'h100; f3[0] = 3'b010;
        addr[1] = 32'h200; f3[1] = 3'b010;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("cont_gnt", {30'h0, gnt}, (k % 2 == 0) ? 32'd1 : 32'd2);
            tick();
            if (k == 3) req = 2'b00;
            chk("cont_rvalid", {30'h0, rvalid}, (k % 2 == 0) ? 32'd1 : 32'd2);
            chk("cont_rdata", rdata[k % 2], (k % 2 == 0) ? 32'hA0A0_0100 : 32'hB1B1_0200);
        end
        tick();
        chk("cont_idle", {28'h0, gnt, rvalid}, 32'h0);

        // Single store / load
        do_access(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 3'b010, 32'h0, 1'b0);
        do_access(0, 1'b0, 32'h10, 32'h0, 3'b010, 32'hDEAD_BEEF, 1'b0);

        // Sub-word accesses
        do_access(1, 1'b1, 32'h21, 32'h1234_5680, 3'b000, 32'h0, 1'b0);
        do_access(1, 1'b0, 32'h21, 32'h0, 3'b000, 32'hFFFF_FF80, 1'b0);
        do_access(0, 1'b0, 32'h21, 32'h0, 3'b100, 32'h0000_0080, 1'b0);
        do_access(0, 1'b1, 32'h22, 32'h5555_8001, 3'b001, 32'h0, 1'b0);
        do_access(1, 1'b0, 32'h22, 32'h0, 3'b001, 32'hFFFF_8001, 1'b0);
        do_access(1, 1'b0, 32'h22, 32'h0, 3'b101, 32'h0000_8001, 1'b0);
        do_access(0, 1'b0, 32'h20, 32'h0, 3'b010, 32'h8001_8000, 1'b0);

        // Alignment and range errors, plus the last legal word
        do_access(0, 1'b0, 32'h13, 32'h0, 3'b010, 32'h0, 1'b1);
        do_access(1, 1'b1, 32'hFFF, 32'hCAFE, 3'b001, 32'h0, 1'b1);
        chk("sh_fff_mem", {24'h0, mem[12'hFFF]}, 32'h11);
        do_access(0, 1'b1, 32'd4096, 32'h7777_7777, 3'b010, 32'h0, 1'b1);
        do_access(0, 1'b0, 32'hFFC, 32'h0, 3'b010, 32'h1122_3344, 1'b0);
        do_access(1, 1'b0, 32'hFFE, 32'h0, 3'b101, 32'h0000_1122, 1'b0);

        // Illegal funct3
        do_access(0, 1'b0, 32'h10, 32'h0, 3'b011, 32'h0, 1'b1);
        do_access(1, 1'b1, 32'h10, 32'h9999_9999, 3'b100, 32'h0, 1'b1);
        chk("illegal_mem", mem_word(32'h10), 32'hDEAD_BEEF);

        // Reset during ACCESS of a store by r0
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h40; wdata[0] = 32'h1234_5678; f3[0] = 3'b010;
        tick();
        chk("rstacc_gnt", {30'h0, gnt}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rstacc_strobe_gated", {31'h0, mem_write}, 32'h0);
        tick();
        rst = 1'b0; req = 2'b00;
        chk("rstacc_rvalid", {30'h0, rvalid}, 32'h0);
        chk("rstacc_gnt_after", {30'h0, gnt}, 32'h0);
        chk("rstacc_mem_addr", mem_addr, 32'h0);
        chk("rstacc_mem_wdata", mem_wdata, 32'h0);
        chk("rstacc_mem_funct3", {29'h0, mem_funct3}, 32'h0);
        chk("rstacc_mem40", mem_word(32'h40), 32'hA5A5_A5A5);
        req = 2'b11; we = 2'b00;
        addr[0] = 32'h40; f3[0] = 3'b010;
        addr[1] = 32'h200; f3[1] = 3'b010;
        tick();
        chk("rstacc_next_gnt", {30'h0, gnt}, 32'd1);
        req = 2'b00;
        tick();
        chk("rstacc_next_rvalid", {30'h0, rvalid}, 32'd1);
        chk("rstacc_next_rdata", rdata[0], 32'hA5A5_A5A5);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
